// File: rtl/cla_sum_pipe.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshakes on both sides.
// Stage 1 registers generate/propagate; stage 2 resolves carries with two-level lookahead.
module cla_sum_pipe #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout_out,
   output logic             ovf_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] result_count
);

   localparam int unsigned NG = WIDTH / 4;

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0] g_q, g_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             cin_q, cin_d;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             s2_free, accept, move, deliver;
   logic [NG-1:0]    gg, gp;
   logic [NG:0]      cg;
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] sum_n;
   logic             c_top, ovf_n;

   always_comb begin
      s2_free  = !out_valid_q || out_ready;
      in_ready = !s1_valid_q || s2_free;
      accept   = in_valid && in_ready;
      move     = s1_valid_q && s2_free;
      deliver  = out_valid_q && out_ready;
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      p_d        = p_q;
      g_d        = g_q;
      a_msb_d    = a_msb_q;
      b_msb_d    = b_msb_q;
      cin_d      = cin_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         p_d        = a_in ^ b_in;
         g_d        = a_in & b_in;
         a_msb_d    = a_in[WIDTH-1];
         b_msb_d    = b_in[WIDTH-1];
         cin_d      = cin_in;
      end else if (move) begin
         s1_valid_d = 1'b0;
      end
   end

   // Group carries are sum-of-products over all lower groups, so no carry ripples between groups.
   always_comb begin : lookahead
      logic [3:0] p4, g4;
      logic       term, acc;
      gg   = '0;
      gp   = '0;
      cg   = '0;
      c    = '0;
      p4   = '0;
      g4   = '0;
      term = 1'b0;
      acc  = 1'b0;
      for (int unsigned k = 0; k < NG; k++) begin
         p4    = p_q[4*k +: 4];
         g4    = g_q[4*k +: 4];
         gg[k] = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
               | (p4[3] & p4[2] & p4[1] & g4[0]);
         gp[k] = &p4;
      end
      for (int unsigned k = 0; k <= NG; k++) begin
         acc = cin_q;
         for (int unsigned j = 0; j < k; j++) acc = acc & gp[j];
         for (int unsigned j = 0; j < k; j++) begin
            term = gg[j];
            for (int unsigned m = j + 1; m < k; m++) term = term & gp[m];
            acc = acc | term;
         end
         cg[k] = acc;
      end
      for (int unsigned k = 0; k < NG; k++) begin
         p4         = p_q[4*k +: 4];
         g4         = g_q[4*k +: 4];
         c[4*k]     = cg[k];
         c[4*k + 1] = g4[0] | (p4[0] & cg[k]);
         c[4*k + 2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & cg[k]);
         c[4*k + 3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
                    | (p4[2] & p4[1] & p4[0] & cg[k]);
      end
      c[WIDTH] = cg[NG];
   end

   // c_top equals c[WIDTH], rebuilt locally from the registered operand MSBs.
   always_comb begin
      sum_n = p_q ^ c[WIDTH-1:0];
      c_top = (a_msb_q & b_msb_q) | ((a_msb_q ^ b_msb_q) & c[WIDTH-1]);
      ovf_n = c_top ^ c[WIDTH-1];
   end

   always_comb begin
      out_valid_d = out_valid_q;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      if (move) begin
         out_valid_d = 1'b1;
         sum_d       = sum_n;
         cout_d      = c[WIDTH];
         ovf_d       = ovf_n;
      end else if (deliver) begin
         out_valid_d = 1'b0;
      end
      count_d = deliver ? count_q + 1'b1 : count_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid_q  <= 1'b0;
         p_q         <= '0;
         g_q         <= '0;
         a_msb_q     <= 1'b0;
         b_msb_q     <= 1'b0;
         cin_q       <= 1'b0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         count_q     <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         p_q         <= p_d;
         g_q         <= g_d;
         a_msb_q     <= a_msb_d;
         b_msb_q     <= b_msb_d;
         cin_q       <= cin_d;
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         count_q     <= count_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign sum_out      = sum_q;
   assign cout_out     = cout_q;
   assign ovf_out      = ovf_q;
   assign result_count = count_q;

endmodule

// File: tb/tb_cla_sum_pipe.sv
// Randomized and directed bench for cla_sum_pipe (4-bit and 16-bit instances) against an arithmetic model.
module tb_cla_sum_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [3:0] a, b, sum;
   logic       cin, in_valid, in_ready, out_ready, cout, ovf, out_valid;
   logic [7:0] result_count;

   logic [15:0] a16, b16, sum16;
   logic        cin16, in_valid16, in_ready16, out_ready16, cout16, ovf16, out_valid16;
   logic [7:0]  rc16;

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;

   logic [5:0] q[$];
   logic [7:0] exp_cnt;
   logic       exp_outv;

   cla_sum_pipe #(.WIDTH(4), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .a_in(a), .b_in(b), .cin_in(cin),
      .in_valid(in_valid), .in_ready(in_ready), .sum_out(sum), .cout_out(cout),
      .ovf_out(ovf), .out_valid(out_valid), .out_ready(out_ready),
      .result_count(result_count)
   );

   cla_sum_pipe #(.WIDTH(16), .CNT_W(8)) dut16 (
      .clk(clk), .reset(reset), .a_in(a16), .b_in(b16), .cin_in(cin16),
      .in_valid(in_valid16), .in_ready(in_ready16), .sum_out(sum16), .cout_out(cout16),
      .ovf_out(ovf16), .out_valid(out_valid16), .out_ready(out_ready16),
      .result_count(rc16)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // {ovf, cout, sum} from integer arithmetic
   function automatic logic [5:0] model4(input int unsigned x, input int unsigned y, input int unsigned c);
      int unsigned u;
      int          sx, sy, s;
      logic        o;
      u  = x + y + c;
      sx = (x >= 8) ? int'(x) - 16 : int'(x);
      sy = (y >= 8) ? int'(y) - 16 : int'(y);
      s  = sx + sy + int'(c);
      o  = (s > 7) || (s < -8);
      return {o, (u > 15) ? 1'b1 : 1'b0, 4'(u)};
   endfunction

   function automatic logic [17:0] model16(input int unsigned x, input int unsigned y, input int unsigned c);
      int unsigned u;
      int          sx, sy, s;
      logic        o;
      u  = x + y + c;
      sx = (x >= 32768) ? int'(x) - 65536 : int'(x);
      sy = (y >= 32768) ? int'(y) - 65536 : int'(y);
      s  = sx + sy + int'(c);
      o  = (s > 32767) || (s < -32768);
      return {o, (u > 65535) ? 1'b1 : 1'b0, 16'(u)};
   endfunction

   // Called at a negedge with inputs already driven; advances exactly one clock.
   task automatic step(output logic acc);
      logic del;
      #1;
      check("in_ready", in_ready, (q.size() < 2) || out_ready);
      check("out_valid", out_valid, exp_outv);
      if (out_valid) begin
         if (q.size() == 0) check("spurious_result", out_valid, 0);
         else begin
            check("sum", sum, q[0][3:0]);
            check("cout", cout, q[0][4]);
            check("ovf", ovf, q[0][5]);
         end
      end
      check("result_count", result_count, exp_cnt);
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      @(posedge clk);
      if (del) begin
         if (q.size() > 0) void'(q.pop_front());
         exp_cnt++;
      end
      if (acc) q.push_back(model4(a, b, cin));
      exp_outv = (q.size() == 2) || (q.size() == 1 && !acc);
      @(negedge clk);
   endtask

   task automatic send(input logic [3:0] x, input logic [3:0] y, input logic c, output int tries);
      logic acc;
      a = x; b = y; cin = c; in_valid = 1'b1;
      tries = 0;
      acc = 1'b0;
      while (!acc && tries < 20) begin
         step(acc);
         tries++;
      end
      if (!acc) check("send_timeout", acc, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      logic acc;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) step(acc);
   endtask

   task automatic directed(input string tag, input logic [3:0] x, input logic [3:0] y, input logic c,
                           input logic [3:0] es, input logic ec, input logic eo);
      int   tries;
      logic acc;
      send(x, y, c, tries);
      step(acc);
      #1;
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_sum"}, sum, es);
      check({tag, "_cout"}, cout, ec);
      check({tag, "_ovf"}, ovf, eo);
      step(acc);
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      #1;
      q.delete();
      exp_cnt = '0;
      exp_outv = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int          tries;
      logic        acc, pend;
      logic [17:0] e16;
      int unsigned x16, y16, c16;

      reset = 1'b0;
      a = '0; b = '0; cin = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a16 = '0; b16 = '0; cin16 = 1'b0; in_valid16 = 1'b0; out_ready16 = 1'b1;
      q.delete();
      exp_cnt = '0;
      exp_outv = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_count", result_count, 0);
      check("rst_sum", sum, 0);
      check("rst_out_valid16", out_valid16, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // 16-bit instance: cross-group carry first, then random operands
      for (int i = 0; i < 21; i++) begin
         if (i == 0) begin x16 = 32'hFFFF; y16 = 0; c16 = 1; end
         else begin x16 = $urandom_range(0, 65535); y16 = $urandom_range(0, 65535); c16 = $urandom_range(0, 1); end
         a16 = 16'(x16); b16 = 16'(y16); cin16 = 1'(c16); in_valid16 = 1'b1;
         #1;
         check("in_ready16", in_ready16, 1);
         @(posedge clk);
         @(negedge clk);
         in_valid16 = 1'b0;
         @(posedge clk);
         @(negedge clk);
         #1;
         e16 = model16(x16, y16, c16);
         check("out_valid16", out_valid16, 1);
         check("sum16", sum16, e16[15:0]);
         check("cout16", cout16, e16[16]);
         check("ovf16", ovf16, e16[17]);
         if (i == 0) begin
            check("cross_group_sum", sum16, 0);
            check("cross_group_cout", cout16, 1);
         end
      end
      @(posedge clk);
      @(negedge clk);
      check("count16", rc16, 21);

      directed("t7p1", 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
      #1;
      check("t7p1_count", result_count, 1);
      directed("tFF1", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0);
      directed("t88", 4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1);
      drain();

      // Backpressure: two ops fill the pipe, the third waits
      out_ready = 1'b0;
      send(4'h1, 4'h2, 1'b0, tries);
      send(4'h3, 4'h4, 1'b1, tries);
      a = 4'h5; b = 4'h6; cin = 1'b0; in_valid = 1'b1;
      step(acc);
      check("bp_third_blocked", acc, 0);
      step(acc);
      check("bp_third_blocked2", acc, 0);
      out_ready = 1'b1;
      step(acc);
      check("bp_third_accept", acc, 1);
      drain();

      // Reset with two operations in flight
      out_ready = 1'b0;
      send(4'h9, 4'h9, 1'b1, tries);
      send(4'h2, 4'h2, 1'b0, tries);
      reset = 1'b0;
      #1;
      check("rst_flight_out_valid", out_valid, 0);
      check("rst_flight_in_ready", in_ready, 1);
      check("rst_flight_count", result_count, 0);
      q.delete();
      exp_cnt = '0;
      exp_outv = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      out_ready = 1'b1;
      repeat (4) step(acc);

      // Back-to-back stream
      for (int i = 0; i < 16; i++) begin
         send(4'(i), 4'(15 - i), 1'(i % 2), tries);
         check("stream_no_bubble", tries, 1);
         in_valid = 1'b1;
      end
      drain();
      check("stream_count", result_count, 16);

      // Random traffic with random backpressure; data held while pending
      pend = 1'b0;
      repeat (300) begin
         if (!pend) begin
            a = 4'($urandom);
            b = 4'($urandom);
            cin = 1'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
         end
         out_ready = ($urandom_range(0, 2) != 0);
         step(acc);
         pend = in_valid && !acc;
      end
      drain();

      // Counter wrap: 257 deliveries from zero
      pulse_reset();
      for (int i = 0; i < 257; i++) begin
         send(4'($urandom), 4'($urandom), 1'($urandom), tries);
         in_valid = 1'b1;
      end
      drain();
      check("wrap_count", result_count, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
